scarv_cop_palu_ctrl: RTL and testbench

SCARV_COP_PALU_CTRL -- requirements
Module: scarv_cop_palu_ctrl

---
 rtl/scarv_cop_palu_ctrl.sv | 111 +++++++++++
 tb/tb_scarv_cop_palu_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_palu_ctrl.sv
// scarv_cop_palu_ctrl: issue/execute/respond sequencer between the coprocessor front end and the PALU
module scarv_cop_palu_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_gpr_rs1,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [31:0] req_imm,
  input  logic [2:0]  req_pw,
  input  logic [3:0]  req_class,
  input  logic [4:0]  req_subclass,
  input  logic [3:0]  req_rd,
  output logic        palu_ivalid,
  output logic [31:0] palu_gpr_rs1,
  output logic [31:0] palu_rs1,
  output logic [31:0] palu_rs2,
  output logic [31:0] palu_rs3,
  output logic [31:0] palu_imm,
  output logic [2:0]  palu_pw,
  output logic [3:0]  palu_class,
  output logic [4:0]  palu_subclass,
  input  logic        palu_idone,
  input  logic [3:0]  palu_ben,
  input  logic [31:0] palu_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic        cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [3:0]  cpr_wben,
  output logic [31:0] cpr_wdata,
  input  logic        flush
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [7:0] TMAX = 8'(TIMEOUT);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  logic [1:0]  state, state_n;
  logic [7:0]  cnt;
  logic        accept, timeout, err_q;
  logic [3:0]  ben_q, rd_q;
  logic [31:0] wdata_q;
  // Handshakes and next state; outputs are gated by reset so nothing escapes while it is held
  always_comb begin
    req_ready   = g_resetn & (state == IDLE) & !flush;
    accept      = req_valid & req_ready;
    timeout     = (state == EXEC) & (cnt == TLAST);
    palu_ivalid = g_resetn & (state == EXEC);
    rsp_valid   = g_resetn & (state == RESP) & !flush;
    rsp_err     = rsp_valid & err_q;
    cpr_wen     = rsp_valid & rsp_ready & |ben_q & !err_q;
    cpr_waddr   = rd_q;
    cpr_wben    = cpr_wen ? ben_q : 4'd0;
    cpr_wdata   = cpr_wen ? wdata_q : 32'd0;
    state_n     = state == IDLE ? (accept ? EXEC : IDLE) :
                  flush         ? IDLE :
                  state == EXEC ? ((palu_idone | timeout) ? RESP : EXEC) :
                  state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  // State, cycle counter, request latches and result capture
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      palu_gpr_rs1  <= 32'd0;
      palu_rs1      <= 32'd0;
      palu_rs2      <= 32'd0;
      palu_rs3      <= 32'd0;
      palu_imm      <= 32'd0;
      palu_pw       <= 3'd0;
      palu_class    <= 4'd0;
      palu_subclass <= 5'd0;
      rd_q          <= 4'd0;
      ben_q         <= 4'd0;
      wdata_q       <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt           <= 8'd0;
        palu_gpr_rs1  <= req_gpr_rs1;
        palu_rs1      <= req_rs1;
        palu_rs2      <= req_rs2;
        palu_rs3      <= req_rs3;
        palu_imm      <= req_imm;
        palu_pw       <= req_pw;
        palu_class    <= req_class;
        palu_subclass <= req_subclass;
        rd_q          <= req_rd;
      end else if (state == EXEC) begin
        cnt <= cnt == TMAX ? cnt : cnt + 8'd1;
      end
      if (state == EXEC && !flush) begin
        if (palu_idone) begin
          ben_q   <= palu_ben;
          wdata_q <= palu_wdata;
          err_q   <= 1'b0;
        end else if (timeout) begin
          ben_q <= 4'd0;
          err_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_scarv_cop_palu_ctrl.sv
// tb_scarv_cop_palu_ctrl: directed scoreboard bench for the PALU controller
module tb_scarv_cop_palu_ctrl;
  localparam int TO = 64;
  logic        g_clk = 0, g_resetn = 0, req_valid = 0, rsp_ready = 0, flush = 0, palu_idone = 0;
  logic [31:0] req_gpr_rs1 = 0, req_rs1 = 0, req_rs2 = 0, req_rs3 = 0, req_imm = 0, palu_wdata = 0;
  logic [2:0]  req_pw = 0;
  logic [3:0]  req_class = 0, req_rd = 0, palu_ben = 0;
  logic [4:0]  req_subclass = 0;
  logic        req_ready, palu_ivalid, rsp_valid, rsp_err, cpr_wen;
  logic [31:0] palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3, palu_imm, cpr_wdata;
  logic [2:0]  palu_pw;
  logic [3:0]  palu_class, cpr_waddr, cpr_wben;
  logic [4:0]  palu_subclass;
  typedef struct packed {logic err; logic wen; logic [3:0] waddr; logic [3:0] wben; logic [31:0] wdata;} rsp_t;
  rsp_t        sb[$];
  rsp_t        got;
  int          checks = 0, failures = 0;
  logic [31:0] lrs1 = 0, lrs2 = 0;
  logic [3:0]  lrd = 0;
  always #5 g_clk = ~g_clk;
  scarv_cop_palu_ctrl #(.TIMEOUT(TO)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_gpr_rs1(req_gpr_rs1), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_imm(req_imm),
    .req_pw(req_pw), .req_class(req_class), .req_subclass(req_subclass), .req_rd(req_rd),
    .palu_ivalid(palu_ivalid), .palu_gpr_rs1(palu_gpr_rs1), .palu_rs1(palu_rs1), .palu_rs2(palu_rs2),
    .palu_rs3(palu_rs3), .palu_imm(palu_imm), .palu_pw(palu_pw), .palu_class(palu_class),
    .palu_subclass(palu_subclass), .palu_idone(palu_idone), .palu_ben(palu_ben), .palu_wdata(palu_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .cpr_wen(cpr_wen),
    .cpr_waddr(cpr_waddr), .cpr_wben(cpr_wben), .cpr_wdata(cpr_wdata), .flush(flush)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [3:0] cls, input rsp_t exp, input bit push);
    @(negedge g_clk);
    req_valid = 1; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_rs3 = rs1 ^ rs2;
    req_imm = 32'h5a; req_gpr_rs1 = rs2 + 1; req_pw = 3'd2; req_class = cls; req_subclass = 5'd1;
    lrs1 = rs1; lrs2 = rs2; lrd = rd;
    #1 chk("req_ready_idle", req_ready, 1);
    if (push) sb.push_back(exp);
    @(negedge g_clk);
    req_valid = 0; req_rs1 = ~rs1; req_rs2 = ~rs2; req_rd = ~rd;
  endtask
  task automatic exec(input int n, input int done_at, input int flush_at, input logic [3:0] ben, input logic [31:0] wd);
    for (int e = 0; e < n; e++) begin
      if (e > 0) @(negedge g_clk);
      palu_idone = (e == done_at); flush = (e == flush_at); palu_ben = ben; palu_wdata = wd;
      #1;
      chk("exec_ivalid", palu_ivalid, 1);
      chk("exec_no_rsp", rsp_valid, 0);
      chk("exec_no_wen", cpr_wen, 0);
      chk("exec_req_ready", req_ready, 0);
      chk("exec_lat_rs1", palu_rs1, lrs1);
      chk("exec_lat_rs2", palu_rs2, lrs2);
    end
    @(negedge g_clk);
    palu_idone = 0; flush = 0; palu_ben = 0; palu_wdata = 0;
  endtask
  task automatic resp(input int hold);
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge g_clk);
      rsp_ready = (k == hold);
      #1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_lat_rd", cpr_waddr, lrd);
      chk("rsp_lat_rs1", palu_rs1, lrs1);
      chk("rsp_ivalid", palu_ivalid, 0);
      if (k < hold) chk("rsp_no_early_wen", cpr_wen, 0);
      else begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("rsp_err", rsp_err, got.err);
          chk("cpr_wen", cpr_wen, got.wen);
          chk("cpr_waddr", cpr_waddr, got.waddr);
          chk("cpr_wben", cpr_wben, got.wben);
          chk("cpr_wdata", cpr_wdata, got.wdata);
        end
      end
    end
    @(negedge g_clk);
    rsp_ready = 0;
    #1;
    chk("post_req_ready", req_ready, 1);
    chk("post_no_rsp", rsp_valid, 0);
    chk("post_no_wen", cpr_wen, 0);
  endtask
  initial begin
    @(negedge g_clk); @(negedge g_clk);
    #1;
    chk("rst_ivalid", palu_ivalid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_wen", cpr_wen, 0);
    chk("rst_wben", cpr_wben, 0);
    chk("rst_wdata", cpr_wdata, 0);
    chk("rst_rs1", palu_rs1, 0);
    g_resetn = 1;
    #1 chk("rst_req_ready", req_ready, 1);
    flush = 1;
    #1 chk("flush_idle_ready", req_ready, 0);
    flush = 0;
    issue(4'd5, 32'h1, 32'h2, 4'd1, '{err: 0, wen: 1, waddr: 5, wben: 4'hF, wdata: 32'h3}, 1);
    exec(1, 0, -1, 4'hF, 32'h3);
    resp(0);
    issue(4'd9, 32'h1234_5678, 32'h0000_0011, 4'd2, '{err: 0, wen: 1, waddr: 9, wben: 4'h3, wdata: 32'hdead_beef}, 1);
    exec(17, 16, -1, 4'h3, 32'hdead_beef);
    resp(3);
    issue(4'd2, 32'haaaa_0000, 32'h5555, 4'd3, '{err: 1, wen: 0, waddr: 2, wben: 0, wdata: 0}, 1);
    exec(TO, -1, -1, 4'hF, 32'h77);
    resp(0);
    issue(4'd7, 32'h10, 32'h20, 4'd4, '{err: 0, wen: 0, waddr: 7, wben: 0, wdata: 0}, 1);
    exec(1, 0, -1, 4'h0, 32'h1234);
    resp(0);
    issue(4'd3, 32'h3, 32'h4, 4'd1, '{err: 0, wen: 0, waddr: 0, wben: 0, wdata: 0}, 0);
    exec(5, 4, 4, 4'hF, 32'h99);
    #1;
    chk("flush_exec_ivalid_off", palu_ivalid, 0);
    chk("flush_exec_no_rsp", rsp_valid, 0);
    chk("flush_exec_ready", req_ready, 1);
    issue(4'd6, 32'h6, 32'h7, 4'd1, '{err: 0, wen: 1, waddr: 6, wben: 4'hC, wdata: 32'hcafe_f00d}, 1);
    exec(2, 1, -1, 4'hC, 32'hcafe_f00d);
    resp(1);
    issue(4'd4, 32'h44, 32'h45, 4'd1, '{err: 0, wen: 0, waddr: 0, wben: 0, wdata: 0}, 0);
    exec(1, 0, -1, 4'hF, 32'h1);
    flush = 1; rsp_ready = 1;
    #1;
    chk("flush_resp_no_rsp", rsp_valid, 0);
    chk("flush_resp_no_wen", cpr_wen, 0);
    @(negedge g_clk);
    flush = 0; rsp_ready = 0;
    #1;
    chk("flush_resp_idle", req_ready, 1);
    chk("flush_resp_rsp_off", rsp_valid, 0);
    @(negedge g_clk);
    flush = 1; req_valid = 1;
    #1 chk("flush_idle_block", req_ready, 0);
    @(negedge g_clk);
    flush = 0; req_valid = 0;
    #1;
    chk("flush_idle_no_exec", palu_ivalid, 0);
    chk("flush_idle_ready_back", req_ready, 1);
    issue(4'd8, 32'h88, 32'h89, 4'd1, '{err: 0, wen: 0, waddr: 0, wben: 0, wdata: 0}, 0);
    exec(1, 0, -1, 4'hF, 32'h55);
    g_resetn = 0; rsp_ready = 1;
    #1;
    chk("rst_resp_no_wen", cpr_wen, 0);
    chk("rst_resp_no_rsp", rsp_valid, 0);
    @(negedge g_clk);
    g_resetn = 1; rsp_ready = 0;
    #1;
    chk("rst_resp_ivalid", palu_ivalid, 0);
    chk("rst_resp_rsp", rsp_valid, 0);
    chk("rst_resp_rs1", palu_rs1, 0);
    chk("rst_resp_waddr", cpr_waddr, 0);
    chk("rst_resp_ready", req_ready, 1);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
